// File: rtl/keyed_dupe_ring_fsm.sv
// Key-locked ring controller with duplicate (trojan) states.
// A ring of NUM_STATES one-hot core states. A +1 step out of lock point
// S(2k+1) with a wrong key[k] lands in duplicate D_k, which mimics its twin
// S(2k+2) on y but bumps a saturating trip counter. Once the counter reaches
// THRESH, a duplicate state's outputs are corrupted by the payload.
module keyed_dupe_ring_fsm #(
    parameter int                   NUM_STATES   = 16,
    parameter int                   NUM_KEYS     = 4,
    parameter logic [NUM_KEYS-1:0]  KEY_VALUE    = 4'b1010,
    parameter int                   THRESH       = 5,
    parameter int                   PAYLOAD_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            x,
    input  logic [NUM_KEYS-1:0]   key,
    output logic [NUM_STATES-1:0] y
);

    localparam int IW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CW = (THRESH > 0) ? $clog2(THRESH + 1) : 1;

    // State is a kind (core/duplicate) plus an index: ring position for
    // core states, lock-point number for duplicates.
    typedef enum logic {
        KIND_CORE = 1'b0,
        KIND_DUP  = 1'b1
    } kind_e;

    kind_e                  kind_q, kind_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_STATES-1:0]  y_q, y_d;
    logic [NUM_STATES-1:0]  mask;
    logic [KW-1:0]          lk_sel;
    logic                   legal;
    int                     cur;
    int                     nxt;
    int                     pos;

    // Ring index of the core state that duplicate k imitates.
    function automatic int twin_of(input int k);
        int t;
        t = 2 * k + 2;
        if (t >= NUM_STATES) t = t - NUM_STATES;
        return t;
    endfunction

    // Next-state, trip counter and next registered output.
    always_comb begin
        kind_d = kind_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        y_d    = y_q;
        mask   = '0;
        lk_sel = '0;
        nxt    = 0;
        pos    = 0;
        legal  = (kind_q == KIND_CORE) ? (int'(idx_q) < NUM_STATES)
                                       : (int'(idx_q) < NUM_KEYS);
        cur    = (kind_q == KIND_CORE) ? int'(idx_q) : twin_of(int'(idx_q));

        if (!legal) begin
            kind_d = KIND_CORE;
            idx_d  = '0;
        end else if (x[2]) begin
            kind_d = KIND_CORE;
            idx_d  = '0;
        end else if (x[0]) begin
            nxt = cur + 1;
            if (nxt >= NUM_STATES) nxt = nxt - NUM_STATES;
            kind_d = KIND_CORE;
            idx_d  = IW'(nxt);
            // Only a +1 step taken from a core lock point S(2k+1) is guarded.
            if (kind_q == KIND_CORE && cur[0] && (cur >> 1) < NUM_KEYS) begin
                lk_sel = KW'(cur >> 1);
                if (key[lk_sel] != KEY_VALUE[lk_sel]) begin
                    kind_d = KIND_DUP;
                    idx_d  = IW'(cur >> 1);
                    if (int'(cnt_q) < THRESH) cnt_d = CW'(int'(cnt_q) + 1);
                end
            end
        end else if (x[1]) begin
            nxt = cur + 2;
            if (nxt >= NUM_STATES) nxt = nxt - NUM_STATES;
            kind_d = KIND_CORE;
            idx_d  = IW'(nxt);
        end

        // Output follows the next state; payload judged on the updated count.
        pos = (kind_d == KIND_CORE) ? int'(idx_d) : twin_of(int'(idx_d));
        mask[IW'(pos)] = 1'b1;
        y_d = mask;
        if (kind_d == KIND_DUP && int'(cnt_d) >= THRESH) begin
            y_d = (PAYLOAD_MODE == 0) ? '0 : ~mask;
        end
    end

    // State, counter and output registers; advance on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            kind_q <= KIND_CORE;
            idx_q  <= '0;
            cnt_q  <= '0;
            y_q    <= NUM_STATES'(1);
        end else begin
            kind_q <= kind_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_keyed_dupe_ring_fsm.sv
// Self-checking bench for keyed_dupe_ring_fsm: vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_keyed_dupe_ring_fsm;

    localparam int          N  = 16;
    localparam int          K  = 4;
    localparam logic [3:0]  KV = 4'b1010;
    localparam int          TH = 5;

    logic        clk;
    logic        rst;
    logic [2:0]  x;
    logic [3:0]  key;
    logic [2:0]  x2;
    logic [1:0]  key2;
    logic [15:0] y0;
    logic [15:0] y1;
    logic [7:0]  y2;

    int checks = 0;
    int errors = 0;

    // Model state: ring position seen at the outputs, duplicate number or -1.
    int m_pos;
    int m_dup;
    int m_cnt;

    keyed_dupe_ring_fsm #(.NUM_STATES(16), .NUM_KEYS(4), .KEY_VALUE(4'b1010),
                          .THRESH(5), .PAYLOAD_MODE(0))
        dut0 (.clk(clk), .rst(rst), .x(x), .key(key), .y(y0));

    keyed_dupe_ring_fsm #(.NUM_STATES(16), .NUM_KEYS(4), .KEY_VALUE(4'b1010),
                          .THRESH(5), .PAYLOAD_MODE(1))
        dut1 (.clk(clk), .rst(rst), .x(x), .key(key), .y(y1));

    keyed_dupe_ring_fsm #(.NUM_STATES(8), .NUM_KEYS(2), .KEY_VALUE(2'b01),
                          .THRESH(5), .PAYLOAD_MODE(0))
        dut2 (.clk(clk), .rst(rst), .x(x2), .key(key2), .y(y2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  xv;
        logic [3:0]  kv;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_dup = -1;
        m_cnt = 0;
    endtask

    task automatic model_edge(input logic [2:0] xv, input logic [3:0] kv);
        int k;
        if (xv[2]) begin
            m_pos = 0;
            m_dup = -1;
        end else if (xv[0]) begin
            k = (m_pos - 1) / 2;
            if (m_dup < 0 && (m_pos % 2) == 1 && k < K && kv[k] != KV[k]) begin
                // Wrong key: same ring destination, but flagged as the duplicate.
                m_dup = k;
                if (m_cnt < TH) m_cnt++;
            end else begin
                m_dup = -1;
            end
            m_pos = (m_pos + 1) % N;
        end else if (xv[1]) begin
            m_pos = (m_pos + 2) % N;
            m_dup = -1;
        end
    endtask

    function automatic logic [15:0] model_y(input int mode);
        logic [15:0] m;
        m = 16'h0001 << m_pos;
        if (m_dup >= 0 && m_cnt >= TH) m = (mode == 0) ? 16'h0000 : ~m;
        return m;
    endfunction

    // One falling edge; leaves time just after the edge for sampling.
    task automatic cyc(input logic [2:0] xv, input logic [3:0] kv);
        x   = xv;
        key = kv;
        @(negedge clk);
        #1;
        model_edge(xv, kv);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_async_y0", y0, 16'h0001);
        chk("rst_async_y2", {8'h00, y2}, 16'h0001);
        model_reset();
        @(posedge clk);
        rst = 1'b0;
    endtask

    // Clear, step to S1, then +1 with wrong key[0] into D0.
    task automatic wrong_entry0();
        cyc(3'b100, KV);
        cyc(3'b001, KV);
        chk("core_s1_clean", y0, 16'h0002);
        cyc(3'b001, 4'b1011);
    endtask

    initial begin
        rst  = 1'b1;
        x    = 3'b000;
        key  = KV;
        x2   = 3'b000;
        key2 = 2'b00;
        model_reset();
        #1;
        chk("reset_y0", y0, 16'h0001);
        chk("reset_y1", y1, 16'h0001);
        chk("reset_y2", {8'h00, y2}, 16'h0001);
        @(posedge clk);
        rst = 1'b0;

        // Vector table from S0 with a fresh counter.
        tbl[0]  = '{3'b001, 4'b1010, 16'h0002, 16'h0002};
        tbl[1]  = '{3'b001, 4'b1011, 16'h0004, 16'h0004};
        tbl[2]  = '{3'b000, 4'b1011, 16'h0004, 16'h0004};
        tbl[3]  = '{3'b001, 4'b1011, 16'h0008, 16'h0008};
        tbl[4]  = '{3'b001, 4'b1010, 16'h0010, 16'h0010};
        tbl[5]  = '{3'b010, 4'b1010, 16'h0040, 16'h0040};
        tbl[6]  = '{3'b100, 4'b1010, 16'h0001, 16'h0001};
        tbl[7]  = '{3'b001, 4'b1011, 16'h0002, 16'h0002};
        tbl[8]  = '{3'b010, 4'b1011, 16'h0008, 16'h0008};
        tbl[9]  = '{3'b001, 4'b1001, 16'h0010, 16'h0010};
        tbl[10] = '{3'b111, 4'b1001, 16'h0001, 16'h0001};
        tbl[11] = '{3'b010, 4'b1010, 16'h0004, 16'h0004};
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].xv, tbl[i].kv);
            chk($sformatf("vec%0d_y0", i), y0, tbl[i].e0);
            chk($sformatf("vec%0d_y1", i), y1, tbl[i].e1);
        end

        // Unlocked walk with the correct key, including wrap.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(3'b001, KV);
            chk($sformatf("walk%0d", i), y0, 16'h0001 << ((i + 1) % 16));
        end

        // Five wrong entries into D0: payload on the fifth, both modes.
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            wrong_entry0();
            chk($sformatf("entry%0d_m0", e), y0, (e < 5) ? 16'h0004 : 16'h0000);
            chk($sformatf("entry%0d_m1", e), y1, (e < 5) ? 16'h0004 : 16'hFFFB);
        end
        cyc(3'b000, KV);
        chk("payload_hold_m0", y0, 16'h0000);
        chk("payload_hold_m1", y1, 16'hFFFB);
        cyc(3'b001, KV);
        chk("core_s3_after_payload", y0, 16'h0008);

        // +2 wrap from S15.
        cyc(3'b100, KV);
        for (int i = 0; i < 7; i++) cyc(3'b010, KV);
        cyc(3'b001, KV);
        chk("reach_s15", y0, 16'h8000);
        cyc(3'b010, KV);
        chk("wrap_plus2", y0, 16'h0002);
        cyc(3'b010, 4'b0101);
        chk("plus2_no_lock", y0, 16'h0008);

        // Clear out of D2.
        do_reset();
        cyc(3'b010, KV);
        cyc(3'b010, KV);
        cyc(3'b001, KV);
        chk("reach_s5", y0, 16'h0020);
        cyc(3'b001, 4'b1110);
        chk("enter_d2", y0, 16'h0040);
        cyc(3'b111, KV);
        chk("clear_from_d2", y0, 16'h0001);

        // Asynchronous reset mid-cycle after four wrong entries.
        do_reset();
        for (int e = 0; e < 4; e++) wrong_entry0();
        chk("pre_rst_d0", y0, 16'h0004);
        #2;
        do_reset();
        wrong_entry0();
        chk("post_rst_entry1", y0, 16'h0004);

        // Counter saturation over many entries.
        do_reset();
        for (int e = 1; e <= 300; e++) begin
            wrong_entry0();
            chk($sformatf("sat%0d_m0", e), y0, (e < 5) ? 16'h0004 : 16'h0000);
            if (e % 50 == 0) chk($sformatf("sat%0d_m1", e), y1, 16'hFFFB);
        end

        // Eight-state, two-key instance: wrong key[1] at S3.
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            x2 = 3'b100; cyc(3'b000, KV);
            x2 = 3'b010; cyc(3'b000, KV);
            x2 = 3'b001; key2 = 2'b11; cyc(3'b000, KV);
            chk("n8_s3", {8'h00, y2}, 16'h0008);
            x2 = 3'b001; key2 = 2'b11; cyc(3'b000, KV);
            chk($sformatf("n8_entry%0d", e), {8'h00, y2}, (e < 5) ? 16'h0010 : 16'h0000);
        end
        x2 = 3'b100; key2 = 2'b01; cyc(3'b000, KV);
        x2 = 3'b010; cyc(3'b000, KV);
        x2 = 3'b001; cyc(3'b000, KV);
        x2 = 3'b001; cyc(3'b000, KV);
        chk("n8_correct_key", {8'h00, y2}, 16'h0010);
        x2 = 3'b000;

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [2:0] xr;
            logic [3:0] kr;
            r = int'($urandom % 16);
            if (r < 6)       xr = 3'b001;
            else if (r < 10) xr = 3'b010;
            else if (r < 12) xr = 3'b000;
            else if (r < 13) xr = 3'b100;
            else             xr = 3'($urandom);
            kr = KV;
            if ($urandom % 3 == 0) kr = kr ^ (4'b0001 << ($urandom % 4));
            if ($urandom % 600 == 0) begin
                #2;
                do_reset();
            end
            cyc(xr, kr);
            chk("rand_y0", y0, model_y(0));
            chk("rand_y1", y1, model_y(1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
